shift_add_mult16: RTL



---
 rtl/shift_add_mult16.sv | 119 +++++++++++
 1 files changed

// File: rtl/shift_add_mult16.sv
// shift_add_mult16: iterative unsigned shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous abort back to IDLE; the operation in flight is discarded
//   in_valid   operands a/b valid
//   in_ready   block accepts operands (IDLE only)
//   a, b       unsigned multiplicand / multiplier
//   out_valid  product valid, held until taken
//   out_ready  consumer accepts product
//   product    registered a*b, stable while out_valid is high
//   busy       high while the partial products are being accumulated
//
// One partial product is added per clock for exactly WIDTH cycles, with no
// early exit, so latency is fixed. The adder is a full 2*WIDTH-bit add with a
// zero carry-in; its carry-out is not kept because the running sum never
// exceeds (2^WIDTH-1)^2.
module shift_add_mult16 #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t               state_q, state_d;
   logic [2*WIDTH-1:0]   m_q, m_d;
   logic [WIDTH-1:0]     q_q, q_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   product_q, product_d;

   logic [2*WIDTH-1:0]   add_a, add_b, sum;
   logic                 add_ci;
   logic                 last;

   // Adder operands: accumulator plus the shifted multiplicand when the
   // current multiplier bit is set.
   always_comb begin
      add_a  = acc_q;
      add_b  = q_q[0] ? m_q : '0;
      add_ci = 1'b0;
      sum    = add_a + add_b + {{(2*WIDTH-1){1'b0}}, add_ci};
   end

   assign last = (cnt_q == CNT_W'(WIDTH-1));

   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      q_d       = q_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      if (flush) begin
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               m_d     = {{WIDTH{1'b0}}, a};
               q_d     = b;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = BUSY;
            end
            BUSY: begin
               acc_d = sum;
               m_d   = m_q << 1;
               q_d   = q_q >> 1;
               cnt_d = cnt_q + 1'b1;
               if (last) begin
                  state_d   = DONE;
                  product_d = sum;
               end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         m_q       <= '0;
         q_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         q_q       <= q_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q == BUSY);
   assign out_valid = (state_q == DONE);
   assign product   = product_q;

endmodule
